ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_pkg.sv | 17 +
 rtl/ras_ckpt_file.sv | 63 ++++++
 rtl/ras_ckpt.sv | 162 ++++++++++++++++
 tb/tb_ras_ckpt.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared types and constants for the checkpointed return-address stack.
package ras_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    REPL = 2'd3
  } ras_op_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ras_ckpt_file.sv
// Checkpoint queue for ras_ckpt: circular slot array with head (oldest) and tail (next free).
// Pointers carry one extra wrap bit so a full queue is distinguishable from an empty one.
module ras_ckpt_file #(
  parameter int NCKPT = 4,
  parameter int DW    = 8,
  parameter int IW    = $clog2(NCKPT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic          i_commit,
  input  logic          i_restore,
  input  logic [IW-1:0] i_restore_id,
  input  logic [DW-1:0] i_data,
  output logic          o_ready,
  output logic [IW-1:0] o_id,
  output logic          o_rst_ok,
  output logic [DW-1:0] o_rst_data
);

  localparam logic [IW:0] OCC_FULL = (IW+1)'(NCKPT);

  logic [DW-1:0] r_slot [NCKPT];
  logic [IW:0]   r_head;
  logic [IW:0]   r_tail;
  logic [IW:0]   w_occ;
  logic [IW-1:0] w_off;
  logic          w_alloc;
  logic          w_take;

  assign w_occ      = r_tail - r_head;
  assign o_ready    = (w_occ != OCC_FULL);
  assign o_id       = r_tail[IW-1:0];
  // Age of the requested slot relative to the oldest; live when younger than occupancy.
  assign w_off      = i_restore_id - r_head[IW-1:0];
  assign w_alloc    = ({1'b0, w_off} < w_occ);
  assign o_rst_ok   = i_restore && w_alloc;
  assign o_rst_data = r_slot[i_restore_id];
  assign w_take     = i_req && o_ready && !o_rst_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (o_rst_ok) begin
      r_tail <= r_head + {1'b0, w_off};
      // Rolling back to the oldest slot empties the queue, so a commit has nothing to release.
      if (i_commit && (w_off != '0))
        r_head <= r_head + 1'b1;
    end else begin
      if (w_take)
        r_tail <= r_tail + 1'b1;
      if (i_commit && (w_occ != '0))
        r_head <= r_head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_take)
      r_slot[r_tail[IW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ras_ckpt.sv
// Return-address stack with checkpoint/restore; optional event counters under RAS_CKPT_STATS_EN.
// Without the macro the counter ports are tied to zero and no counter flops exist.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NCKPT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  input  logic                     ckpt_req,
  output logic                     ckpt_ready,
  output logic [$clog2(NCKPT)-1:0] ckpt_id,
  input  logic                     commit,
  input  logic                     restore,
  input  logic [$clog2(NCKPT)-1:0] restore_id,
  output logic [STAT_W-1:0]        ovf_cnt,
  output logic [STAT_W-1:0]        unf_cnt,
  output logic [STAT_W-1:0]        rst_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + CW + WIDTH;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_tosp;
  logic [CW-1:0]    r_cnt;

  ras_op_e          w_op;
  logic [AW-1:0]    w_tosp_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic             w_wr;
  logic [WIDTH-1:0] w_top_nx;
  logic             w_rst_ok;
  logic [SW-1:0]    w_rst_data;
  logic [AW-1:0]    w_sv_tosp;
  logic [CW-1:0]    w_sv_cnt;
  logic [WIDTH-1:0] w_sv_top;

  assign empty = (r_cnt == '0);
  assign dout  = empty ? '0 : r_mem[r_tosp];

  always_comb begin
    w_op = NOP;
    case ({push, pop})
      2'b10:   w_op = PUSH;
      2'b01:   w_op = POP;
      2'b11:   w_op = REPL;
      default: w_op = NOP;
    endcase
    if (w_rst_ok)
      w_op = NOP;
    // Replacing the top of an empty stack is just a push.
    if ((w_op == REPL) && empty)
      w_op = PUSH;
  end

  always_comb begin
    w_tosp_nx = r_tosp;
    w_cnt_nx  = r_cnt;
    w_wr      = 1'b0;
    case (w_op)
      PUSH: begin
        w_tosp_nx = r_tosp + 1'b1;
        w_cnt_nx  = (r_cnt == CNT_FULL) ? r_cnt : r_cnt + 1'b1;
        w_wr      = 1'b1;
      end
      POP: begin
        if (!empty) begin
          w_tosp_nx = r_tosp - 1'b1;
          w_cnt_nx  = r_cnt - 1'b1;
        end
      end
      REPL:    w_wr = 1'b1;
      default: ;
    endcase
  end

  // Top value as it will be after this cycle's stack operation, for the checkpoint snapshot.
  assign w_top_nx = w_wr ? din : r_mem[w_tosp_nx];

  ras_ckpt_file #(
    .NCKPT (NCKPT),
    .DW    (SW)
  ) u_ckpt_file (
    .clk          (clk),
    .reset        (reset),
    .i_req        (ckpt_req),
    .i_commit     (commit),
    .i_restore    (restore),
    .i_restore_id (restore_id),
    .i_data       ({w_tosp_nx, w_cnt_nx, w_top_nx}),
    .o_ready      (ckpt_ready),
    .o_id         (ckpt_id),
    .o_rst_ok     (w_rst_ok),
    .o_rst_data   (w_rst_data)
  );

  assign {w_sv_tosp, w_sv_cnt, w_sv_top} = w_rst_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tosp <= '0;
      r_cnt  <= '0;
    end else if (w_rst_ok) begin
      r_tosp <= w_sv_tosp;
      r_cnt  <= w_sv_cnt;
    end else begin
      r_tosp <= w_tosp_nx;
      r_cnt  <= w_cnt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_rst_ok)
        r_mem[w_sv_tosp] <= w_sv_top;
      else if (w_wr)
        r_mem[w_tosp_nx] <= din;
    end
  end

`ifdef RAS_CKPT_STATS_EN
  logic [STAT_W-1:0] r_ovf_cnt;
  logic [STAT_W-1:0] r_unf_cnt;
  logic [STAT_W-1:0] r_rst_cnt;
  logic              w_ovf;
  logic              w_unf;

  assign w_ovf = (w_op == PUSH) && (r_cnt == CNT_FULL);
  assign w_unf = (w_op == POP) && empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
      r_rst_cnt <= '0;
    end else begin
      if (w_ovf)    r_ovf_cnt <= sat_inc(r_ovf_cnt);
      if (w_unf)    r_unf_cnt <= sat_inc(r_unf_cnt);
      if (w_rst_ok) r_rst_cnt <= sat_inc(r_rst_cnt);
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign unf_cnt = r_unf_cnt;
  assign rst_cnt = r_rst_cnt;
`else
  assign ovf_cnt = '0;
  assign unf_cnt = '0;
  assign rst_cnt = '0;
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
// Self-checking bench for ras_ckpt: directed scenarios plus random traffic against an integer-level model.
module tb_ras_ckpt;

  localparam int D = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        empty;
  logic        ckpt_req = 1'b0;
  logic        ckpt_ready;
  logic [1:0]  ckpt_id;
  logic        commit = 1'b0;
  logic        restore = 1'b0;
  logic [1:0]  restore_id = '0;
  logic [15:0] ovf_cnt, unf_cnt, rst_cnt;

  ras_ckpt #(.WIDTH(32), .DEPTH(D), .NCKPT(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .empty      (empty),
    .ckpt_req   (ckpt_req),
    .ckpt_ready (ckpt_ready),
    .ckpt_id    (ckpt_id),
    .commit     (commit),
    .restore    (restore),
    .restore_id (restore_id),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt),
    .rst_cnt    (rst_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: stack as an integer-indexed ring, checkpoints as a head/occupancy ring.
  logic [31:0] m_mem [D];
  int          m_tosp, m_cnt, m_head, m_occ;
  int          m_ovf, m_unf, m_rst;
  int          s_tosp [N];
  int          s_cnt  [N];
  logic [31:0] s_top  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_step(input logic rs, input logic ps, input logic pp, input logic [31:0] d,
                            input logic cr, input logic cm, input logic rt, input logic [1:0] rid);
    int off, tail, old_occ;
    if (rs) begin
      m_tosp = 0; m_cnt = 0; m_head = 0; m_occ = 0;
      m_ovf = 0; m_unf = 0; m_rst = 0;
      return;
    end
    off = (int'(rid) - m_head + N) % N;
    if (rt && (off < m_occ)) begin
      m_tosp = s_tosp[rid];
      m_cnt  = s_cnt[rid];
      m_mem[m_tosp] = s_top[rid];
      if (cm && off != 0) begin
        m_head = (m_head + 1) % N;
        m_occ  = off - 1;
      end else begin
        m_occ = off;
      end
      m_rst = sat(m_rst);
    end else begin
      if (ps && (!pp || m_cnt == 0)) begin
        m_tosp = (m_tosp + 1) % D;
        m_mem[m_tosp] = d;
        if (m_cnt == D) m_ovf = sat(m_ovf);
        else m_cnt++;
      end else if (ps && pp) begin
        m_mem[m_tosp] = d;
      end else if (pp) begin
        if (m_cnt == 0) m_unf = sat(m_unf);
        else begin
          m_tosp = (m_tosp + D - 1) % D;
          m_cnt--;
        end
      end
      tail = (m_head + m_occ) % N;
      old_occ = m_occ;
      if (cr && m_occ < N) begin
        s_tosp[tail] = m_tosp;
        s_cnt[tail]  = m_cnt;
        s_top[tail]  = m_mem[m_tosp];
        m_occ++;
      end
      if (cm && old_occ > 0) begin
        m_head = (m_head + 1) % N;
        m_occ--;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] e_dout;
    int e_ovf, e_unf, e_rst;
    e_dout = (m_cnt > 0) ? m_mem[m_tosp] : 32'h0;
`ifdef RAS_CKPT_STATS_EN
    e_ovf = m_ovf; e_unf = m_unf; e_rst = m_rst;
`else
    e_ovf = 0; e_unf = 0; e_rst = 0;
`endif
    chk("dout",       dout,               e_dout);
    chk("empty",      {31'b0, empty},      (m_cnt == 0) ? 32'd1 : 32'd0);
    chk("ckpt_ready", {31'b0, ckpt_ready}, (m_occ < N) ? 32'd1 : 32'd0);
    chk("ckpt_id",    {30'b0, ckpt_id},    32'((m_head + m_occ) % N));
    chk("ovf_cnt",    {16'b0, ovf_cnt},    32'(e_ovf));
    chk("unf_cnt",    {16'b0, unf_cnt},    32'(e_unf));
    chk("rst_cnt",    {16'b0, rst_cnt},    32'(e_rst));
  endtask

  task automatic step(input logic rs, input logic ps, input logic pp, input logic [31:0] d,
                      input logic cr, input logic cm, input logic rt, input logic [1:0] rid);
    @(negedge clk);
    reset = rs; push = ps; pop = pp; din = d;
    ckpt_req = cr; commit = cm; restore = rt; restore_id = rid;
    @(posedge clk);
    model_step(rs, ps, pp, d, cr, cm, rt, rid);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_push(input logic [31:0] d);
    step(0, 1, 0, d, 0, 0, 0, 0);
  endtask

  task automatic do_pop();
    step(0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    for (int i = 0; i < N; i++) begin s_tosp[i] = 0; s_cnt[i] = 0; s_top[i] = '0; end
    m_tosp = 0; m_cnt = 0; m_head = 0; m_occ = 0; m_ovf = 0; m_unf = 0; m_rst = 0;

    // LIFO order and underflow
    do_reset();
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_dout",  dout, 32'h0);
    do_push(32'hA1); do_push(32'hA2); do_push(32'hA3);
    chk("lifo_top", dout, 32'hA3);
    do_pop(); chk("lifo_pop1", dout, 32'hA2);
    do_pop(); chk("lifo_pop2", dout, 32'hA1);
    do_pop(); chk("lifo_pop3", dout, 32'h0);
    chk("lifo_empty", {31'b0, empty}, 32'd1);
    do_pop();

    // Overflow wraps over the oldest entry
    do_reset();
    for (int i = 1; i <= 5; i++) do_push(32'hB0 + 32'(i));
    chk("ovf_top", dout, 32'hB5);
    for (int i = 0; i < 3; i++) do_pop();
    chk("ovf_b2", dout, 32'hB2);
    do_pop();
    chk("ovf_empty", {31'b0, empty}, 32'd1);

    // Basic checkpoint and rollback
    do_reset();
    do_push(32'hC1); do_push(32'hC2);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    do_pop(); do_push(32'hD9);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("rb_dout", dout, 32'hC2);
    chk("rb_ready", {31'b0, ckpt_ready}, 32'd1);
    chk("rb_id", {30'b0, ckpt_id}, 32'd0);

    // Queue full, ignored request, commit, partial rollback
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("q_full", {31'b0, ckpt_ready}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("q_commit_ready", {31'b0, ckpt_ready}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    chk("q_restore_id", {30'b0, ckpt_id}, 32'd2);

    // Snapshot includes same-cycle push; restore drops same-cycle push
    do_reset();
    step(0, 1, 0, 32'hE1, 1, 0, 0, 0);
    do_pop(); do_pop();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("snap_e1", dout, 32'hE1);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 32'hF1, 0, 0, 1, 0);
    chk("drop_f1", dout, 32'hE1);

    // Reset overrides a restore with live checkpoints
    do_push(32'h11);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h20 + 32'(i), 1, 0, 0, 0);
    step(1, 1, 0, 32'h99, 1, 1, 1, 1);
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_id", {30'b0, ckpt_id}, 32'd0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) == 0),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 19) < 3,
           2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
